// File: rtl/core_ctrl_fsm.sv
// Multicycle RV32I control sequencer: fetch/decode/execute/mem/writeback steering,
// memory-handshake timeout, illegal-opcode trap and retired-instruction counter.
`timescale 1ns/1ps
module core_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT     = 255,
  parameter bit          TRAP_ON_TIMEOUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_valid,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMMED = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // Stall count is compared against limit-1 so the trap lands on the MEM_TIMEOUT-th stalled cycle.
  localparam logic [15:0] TO_LIMIT = 16'(MEM_TIMEOUT - 32'd1);

  function automatic logic is_legal(input logic [6:0] opc);
    logic ok;
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
      OPC_OP_IMMED, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_MISC_MEM: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] to_cnt_r;
  logic [31:0] instret_r;
  logic [1:0]  trap_cause_r, cause_nxt_s;
  logic [6:0]  opc_s;
  logic        mem_req_s, hs_s, stall_s, timeout_s, retire_s;
  logic        mem_valid_s, mem_we_s, mem_addr_sel_s, ir_we_s, pc_we_s;
  logic        rf_we_s, alu_a_sel_s, alu_b_sel_s, trap_s;
  logic [1:0]  pc_sel_s, wb_sel_s;
  logic        unused_inst_s;

  assign opc_s         = inst[6:0];
  assign unused_inst_s = ^inst[31:7];
  assign mem_req_s     = (state_r == S_FETCH) || (state_r == S_MEM);
  assign hs_s          = mem_req_s && mem_ready;
  assign stall_s       = mem_req_s && !mem_ready;
  assign timeout_s     = (TRAP_ON_TIMEOUT == 1'b1) && stall_s && (to_cnt_r >= TO_LIMIT);

  // Next-state and control-output decode from current state and opcode.
  always_comb begin
    state_nxt_s    = state_r;
    cause_nxt_s    = 2'd0;
    mem_valid_s    = 1'b0;
    mem_we_s       = 1'b0;
    mem_addr_sel_s = 1'b0;
    ir_we_s        = 1'b0;
    pc_we_s        = 1'b0;
    pc_sel_s       = 2'd0;
    rf_we_s        = 1'b0;
    wb_sel_s       = 2'd0;
    alu_a_sel_s    = 1'b0;
    alu_b_sel_s    = 1'b0;
    trap_s         = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_valid_s = 1'b1;
        if (hs_s) begin
          ir_we_s     = 1'b1;
          state_nxt_s = S_DECODE;
        end else if (timeout_s) begin
          state_nxt_s = S_TRAP;
          cause_nxt_s = 2'd2;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if ((inst[1:0] != 2'b11) || !is_legal(opc_s)) begin
          state_nxt_s = S_TRAP;
          cause_nxt_s = 2'd1;
        end else begin
          state_nxt_s = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_nxt_s = S_FETCH;
        case (opc_s)
          OPC_OP, OPC_OP_IMMED: begin
            alu_b_sel_s = (opc_s == OPC_OP_IMMED);
            rf_we_s     = 1'b1;
            pc_we_s     = 1'b1;
          end
          OPC_LUI: begin
            rf_we_s  = 1'b1;
            wb_sel_s = 2'd3;
            pc_we_s  = 1'b1;
          end
          OPC_AUIPC: begin
            alu_a_sel_s = 1'b1;
            alu_b_sel_s = 1'b1;
            rf_we_s     = 1'b1;
            pc_we_s     = 1'b1;
          end
          OPC_JAL, OPC_JALR: begin
            alu_a_sel_s = (opc_s == OPC_JAL);
            alu_b_sel_s = 1'b1;
            rf_we_s     = 1'b1;
            wb_sel_s    = 2'd2;
            pc_we_s     = 1'b1;
            pc_sel_s    = 2'd1;
          end
          OPC_BRANCH: begin
            alu_a_sel_s = 1'b1;
            alu_b_sel_s = 1'b1;
            pc_we_s     = 1'b1;
            pc_sel_s    = branch_taken ? 2'd1 : 2'd0;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_b_sel_s = 1'b1;
            state_nxt_s = S_MEM;
          end
          OPC_MISC_MEM: begin
            pc_we_s = 1'b1;
          end
          // Instruction changed under us after decode: treat as illegal.
          default: begin
            state_nxt_s = S_TRAP;
            cause_nxt_s = 2'd1;
          end
        endcase
      end
      S_MEM: begin
        mem_valid_s    = 1'b1;
        mem_addr_sel_s = 1'b1;
        mem_we_s       = (opc_s == OPC_STORE);
        alu_b_sel_s    = 1'b1;
        if (hs_s) begin
          if (opc_s == OPC_STORE) begin
            pc_we_s     = 1'b1;
            state_nxt_s = S_FETCH;
          end else begin
            state_nxt_s = S_WB;
          end
        end else if (timeout_s) begin
          state_nxt_s = S_TRAP;
          cause_nxt_s = 2'd2;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB: begin
        rf_we_s     = 1'b1;
        wb_sel_s    = 2'd1;
        pc_we_s     = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_TRAP: begin
        trap_s      = 1'b1;
        pc_we_s     = 1'b1;
        pc_sel_s    = 2'd2;
        state_nxt_s = S_FETCH;
      end
      default: begin
        state_nxt_s = S_FETCH;
      end
    endcase
  end

  assign retire_s = (state_nxt_s == S_FETCH) &&
                    ((state_r == S_EXECUTE) || (state_r == S_MEM) || (state_r == S_WB));

  // State, stall counter, retire counter and sticky trap cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_FETCH;
      to_cnt_r     <= 16'd0;
      instret_r    <= 32'd0;
      trap_cause_r <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      if (stall_s && (state_nxt_s == state_r)) begin
        to_cnt_r <= (to_cnt_r < TO_LIMIT) ? (to_cnt_r + 16'd1) : to_cnt_r;
      end else begin
        to_cnt_r <= 16'd0;
      end
      instret_r    <= retire_s ? (instret_r + 32'd1) : instret_r;
      trap_cause_r <= (state_nxt_s == S_TRAP) ? cause_nxt_s : trap_cause_r;
    end
  end

  // Gating with rst_n drops the bus request the instant reset asserts.
  assign mem_valid    = rst_n & mem_valid_s;
  assign mem_we       = rst_n & mem_we_s;
  assign mem_addr_sel = rst_n & mem_addr_sel_s;
  assign ir_we        = rst_n & ir_we_s;
  assign pc_we        = rst_n & pc_we_s;
  assign pc_sel       = rst_n ? pc_sel_s : 2'd0;
  assign rf_we        = rst_n & rf_we_s;
  assign wb_sel       = rst_n ? wb_sel_s : 2'd0;
  assign alu_a_sel    = rst_n & alu_a_sel_s;
  assign alu_b_sel    = rst_n & alu_b_sel_s;
  assign trap         = rst_n & trap_s;
  assign trap_cause   = trap_cause_r;
  assign instret      = instret_r;
  assign state_o      = state_r;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed table-driven bench for core_ctrl_fsm (MEM_TIMEOUT = 4).
`timescale 1ns/1ps
module tb_core_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_valid, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
  logic        alu_a_sel, alu_b_sel, trap;
  logic [1:0]  pc_sel, wb_sel, trap_cause;
  logic [31:0] instret;
  logic [2:0]  state_o;
  logic [17:0] act_ctl;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h0000A103;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] SW   = 32'h00112223;
  localparam logic [31:0] JAL  = 32'h0080006F;
  localparam logic [31:0] LUI  = 32'h123450B7;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] BAD  = 32'hFFFFFFFF;

  always #5 clk = ~clk;

  core_ctrl_fsm #(.MEM_TIMEOUT(4), .TRAP_ON_TIMEOUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .trap(trap), .trap_cause(trap_cause), .instret(instret), .state_o(state_o)
  );

  assign act_ctl = {state_o, mem_valid, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                    rf_we, wb_sel, alu_a_sel, alu_b_sel, trap, trap_cause};

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        br;
    logic        rdy;
    logic [17:0] ctl;
    logic [31:0] ir;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  // Packs expected controls: state, mem_valid, mem_we, mem_addr_sel, ir_we, pc_we,
  // pc_sel, rf_we, wb_sel, alu_a_sel, alu_b_sel, trap, trap_cause.
  function automatic logic [17:0] c(input logic [2:0] st, input logic mv, mwe, mas, irwe, pcwe,
                                    input logic [1:0] pcs, input logic rfwe, input logic [1:0] wbs,
                                    input logic aa, ab, tr, input logic [1:0] cs);
    return {st, mv, mwe, mas, irwe, pcwe, pcs, rfwe, wbs, aa, ab, tr, cs};
  endfunction

  task automatic check(input string name, input logic [17:0] ec, input logic [31:0] ei);
    checks++;
    if (act_ctl !== ec || instret !== ei) begin
      errors++;
      $display("FAIL %s: got ctl=%05h instret=%08h, expected ctl=%05h instret=%08h",
               name, act_ctl, instret, ec, ei);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic br, input logic rdy);
    inst         = i;
    branch_taken = br;
    mem_ready    = rdy;
  endtask

  task automatic add(input string name, input logic [31:0] i, input logic br, input logic rdy,
                     input logic [17:0] ctl, input logic [31:0] ir);
    vecs.push_back('{name, i, br, rdy, ctl, ir});
  endtask

  task automatic add_simple(input string name, input logic [31:0] i, input logic br,
                            input logic [17:0] exec_ctl, input logic [31:0] ir, input logic [1:0] cs);
    add({name, "_fetch"}, i, 1'b0, 1'b1, c(3'd0,1,0,0,1,0,2'd0,0,2'd0,0,0,0,cs), ir);
    add({name, "_decode"}, i, 1'b0, 1'b1, c(3'd1,0,0,0,0,0,2'd0,0,2'd0,0,0,0,cs), ir);
    add({name, "_exec"}, i, br, 1'b1, exec_ctl, ir);
  endtask

  initial begin
    add_simple("addi", ADDI, 1'b0, c(3'd2,0,0,0,0,1,2'd0,1,2'd0,0,1,0,2'd0), 32'd0, 2'd0);
    add_simple("lw", LW, 1'b0, c(3'd2,0,0,0,0,0,2'd0,0,2'd0,0,1,0,2'd0), 32'd1, 2'd0);
    for (int k = 0; k < 3; k++) add("lw_mem_wait", LW, 1'b0, 1'b0, c(3'd3,1,0,1,0,0,2'd0,0,2'd0,0,1,0,2'd0), 32'd1);
    add("lw_mem_ack", LW, 1'b0, 1'b1, c(3'd3,1,0,1,0,0,2'd0,0,2'd0,0,1,0,2'd0), 32'd1);
    add("lw_wb", LW, 1'b0, 1'b1, c(3'd4,0,0,0,0,1,2'd0,1,2'd1,0,0,0,2'd0), 32'd1);
    add_simple("beq_taken", BEQ, 1'b1, c(3'd2,0,0,0,0,1,2'd1,0,2'd0,1,1,0,2'd0), 32'd2, 2'd0);
    add_simple("beq_not", BEQ, 1'b0, c(3'd2,0,0,0,0,1,2'd0,0,2'd0,1,1,0,2'd0), 32'd3, 2'd0);
    add_simple("sw", SW, 1'b0, c(3'd2,0,0,0,0,0,2'd0,0,2'd0,0,1,0,2'd0), 32'd4, 2'd0);
    add("sw_mem", SW, 1'b0, 1'b1, c(3'd3,1,1,1,0,1,2'd0,0,2'd0,0,1,0,2'd0), 32'd4);
    add_simple("jal", JAL, 1'b0, c(3'd2,0,0,0,0,1,2'd1,1,2'd2,1,1,0,2'd0), 32'd5, 2'd0);
    add_simple("lui", LUI, 1'b0, c(3'd2,0,0,0,0,1,2'd0,1,2'd3,0,0,0,2'd0), 32'd6, 2'd0);
    add_simple("add", ADD, 1'b0, c(3'd2,0,0,0,0,1,2'd0,1,2'd0,0,0,0,2'd0), 32'd7, 2'd0);
    add("bad_fetch", BAD, 1'b0, 1'b1, c(3'd0,1,0,0,1,0,2'd0,0,2'd0,0,0,0,2'd0), 32'd8);
    add("bad_decode", BAD, 1'b0, 1'b1, c(3'd1,0,0,0,0,0,2'd0,0,2'd0,0,0,0,2'd0), 32'd8);
    add("bad_trap", BAD, 1'b0, 1'b1, c(3'd5,0,0,0,0,1,2'd2,0,2'd0,0,0,1,2'd1), 32'd8);
    for (int k = 0; k < 4; k++) add("to_stall", ADDI, 1'b0, 1'b0, c(3'd0,1,0,0,0,0,2'd0,0,2'd0,0,0,0,2'd1), 32'd8);
    add("to_trap", ADDI, 1'b0, 1'b0, c(3'd5,0,0,0,0,1,2'd2,0,2'd0,0,0,1,2'd2), 32'd8);
    for (int k = 0; k < 3; k++) add("to_stall2", ADDI, 1'b0, 1'b0, c(3'd0,1,0,0,0,0,2'd0,0,2'd0,0,0,0,2'd2), 32'd8);
    add_simple("to_ack", ADDI, 1'b0, c(3'd2,0,0,0,0,1,2'd0,1,2'd0,0,1,0,2'd2), 32'd8, 2'd2);

    drive(ADDI, 1'b0, 1'b1);
    #12;
    check("reset", 18'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].inst, vecs[i].br, vecs[i].rdy);
      #1;
      check(vecs[i].name, vecs[i].ctl, vecs[i].ir);
      @(negedge clk);
    end

    // instret wrap: preload the counter, then retire two instructions.
    drive(ADDI, 1'b0, 1'b1);
    force dut.instret_r = 32'hFFFFFFFF;
    #1;
    release dut.instret_r;
    check("wrap_pre", c(3'd0,1,0,0,1,0,2'd0,0,2'd0,0,0,0,2'd2), 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    #1;
    check("wrap_0", c(3'd0,1,0,0,1,0,2'd0,0,2'd0,0,0,0,2'd2), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("wrap_1", c(3'd0,1,0,0,1,0,2'd0,0,2'd0,0,0,0,2'd2), 32'd1);

    // Reset asserted in the middle of a stalled load transfer.
    drive(LW, 1'b0, 1'b1);
    @(negedge clk);
    drive(LW, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("mem_before_rst", c(3'd3,1,0,1,0,0,2'd0,0,2'd0,0,1,0,2'd2), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem", 18'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_fetch", c(3'd0,1,0,0,0,0,2'd0,0,2'd0,0,0,0,2'd0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
